// File: rtl/debug_defs.sv
// Shared debugger definitions: the watch-scan FSM state type and the
// {ShiftDR, CaptureDR} control encodings.
package debug_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } t_scan_state;

  localparam logic [1:0] SCAN_CTRL_IDLE    = 2'b00;
  localparam logic [1:0] SCAN_CTRL_CAPTURE = 2'b01;
  localparam logic [1:0] SCAN_CTRL_SHIFT   = 2'b10;

endpackage

// File: rtl/scan_clk_gen.sv
// Scan clock generator: CLKDIV Clk cycles low, then CLKDIV high, while enabled.
// fall_tick marks the cycle before the falling edge, sample_tick the cycle before the rising edge.
module scan_clk_gen #(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic scan_clk,
  output logic fall_tick,
  output logic sample_tick
);

  localparam int CNTW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKDIV - 1);

  logic [CNTW-1:0] cnt;
  logic            half_end;

  assign half_end = en && (cnt == HALF_LAST);

  // Disabling restarts the phase so every enable begins with a full low half.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt      <= '0;
      scan_clk <= 1'b0;
    end else if (half_end) begin
      cnt      <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fall_tick   = half_end && scan_clk;
  assign sample_tick = half_end && !scan_clk;

endmodule

// File: rtl/watch_scan_master.sv
// Debugger-side master for one CPU watch scan chain: capture, then shift out into oData.
// Optional chain-length check enabled by defining WATCH_SCAN_CHAIN_CHECK_EN.
module watch_scan_master #(
  parameter int MAXLEN = 256,
  parameter int CLKDIV = 2,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              iStart,
  input  logic [LW-1:0]     iLen,
  output logic              oBusy,
  output logic              oDone,
  output logic [MAXLEN-1:0] oData,
  output logic              oChainErr,
  output logic              oScanClk,
  output logic              oScanIn,
  input  logic              iScanOut,
  output logic [1:0]        oScanCtrl
);
  import debug_defs::*;

  // One spare bit so Len plus the check period never wraps.
  localparam int CW = LW + 1;
  localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [LW-1:0] MAXLEN_L = LW'(MAXLEN);
`ifdef WATCH_SCAN_CHAIN_CHECK_EN
  localparam logic [CW-1:0] EXTRA = CW'(1);
`else
  localparam logic [CW-1:0] EXTRA = '0;
`endif

  t_scan_state   state, state_nxt;
  logic [CW-1:0] len_q, bitcnt, nper;
  logic [LW-1:0] len_clamped;
  logic          accept, clk_en, fall_tick, sample_tick, last_per;

  assign accept      = (state == IDLE) && iStart;
  assign len_clamped = (iLen > MAXLEN_L) ? MAXLEN_L : iLen;
  assign nper        = len_q + EXTRA;
  assign last_per    = (bitcnt == nper);
  assign clk_en      = (state == CAPTURE) || (state == SHIFT);
  assign oBusy       = (state != IDLE);
  assign oDone       = (state == DONE);

  scan_clk_gen #(
    .CLKDIV (CLKDIV)
  ) u_clk_gen (
    .clk         (Clk),
    .rst         (Reset),
    .en          (clk_en),
    .scan_clk    (oScanClk),
    .fall_tick   (fall_tick),
    .sample_tick (sample_tick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // State changes only on fall ticks, so oScanCtrl is stable around each rising edge.
  always_comb begin
    state_nxt = state;
    oScanCtrl = SCAN_CTRL_IDLE;
    case (state)
      IDLE: begin
        if (iStart) state_nxt = (iLen == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        oScanCtrl = SCAN_CTRL_CAPTURE;
        if (fall_tick) state_nxt = SHIFT;
      end
      SHIFT: begin
        oScanCtrl = SCAN_CTRL_SHIFT;
        if (fall_tick && last_per) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      len_q  <= '0;
      bitcnt <= '0;
      oData  <= '0;
    end else if (accept) begin
      len_q  <= CW'(len_clamped);
      bitcnt <= '0;
      oData  <= '0;
    end else if ((state == SHIFT) && sample_tick) begin
      if (bitcnt < len_q) oData[bitcnt[IW-1:0]] <= iScanOut;
      bitcnt <= bitcnt + 1'b1;
    end
  end

`ifdef WATCH_SCAN_CHAIN_CHECK_EN
  logic mark_q, chk_q, err_q;

  // A single 1 is shifted in during the first shift period; it must reappear
  // at ScanOut exactly Len periods later if the chain is Len bits long.
  always_ff @(posedge Clk) begin
    if (Reset || accept) begin
      mark_q <= 1'b0;
      chk_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if ((state == CAPTURE) && fall_tick) mark_q <= 1'b1;
      if ((state == SHIFT) && fall_tick) mark_q <= 1'b0;
      if ((state == SHIFT) && sample_tick && (bitcnt == len_q)) chk_q <= iScanOut;
      if ((state == SHIFT) && fall_tick && last_per) err_q <= ~chk_q;
    end
  end

  assign oScanIn   = mark_q;
  assign oChainErr = err_q;
`else
  assign oScanIn   = 1'b0;
  assign oChainErr = 1'b0;
`endif

endmodule

// File: tb/tb_watch_scan_master.sv
// Directed bench for watch_scan_master with a behavioural scan chain model.
module tb_watch_scan_master;

  localparam int MAXLEN = 256;
  localparam int LW     = 9;
`ifdef WATCH_SCAN_CHAIN_CHECK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LW-1:0]     len;
  logic              busy, done, chain_err, scan_clk, scan_in, scan_out;
  logic [MAXLEN-1:0] data;
  logic [1:0]        scan_ctrl;

  int checks = 0;
  int failures = 0;

  watch_scan_master #(
    .MAXLEN (MAXLEN),
    .CLKDIV (2)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .iStart    (start),
    .iLen      (len),
    .oBusy     (busy),
    .oDone     (done),
    .oData     (data),
    .oChainErr (chain_err),
    .oScanClk  (scan_clk),
    .oScanIn   (scan_in),
    .iScanOut  (scan_out),
    .oScanCtrl (scan_ctrl)
  );

  always #5 clk = ~clk;

  // Behavioural chain: capture loads pdata, shift moves toward bit 0, ScanIn enters the MSB.
  logic [255:0] chain = '0;
  logic [255:0] pdata = '0;
  int chain_len = 37;
  int cap_edges = 0;
  int shift_edges = 0;
  int done_cnt = 0;

  always @(posedge scan_clk) begin
    if (scan_ctrl[0]) begin
      chain <= pdata;
      cap_edges <= cap_edges + 1;
    end else if (scan_ctrl[1]) begin
      chain <= chain >> 1;
      chain[chain_len-1] <= scan_in;
      shift_edges <= shift_edges + 1;
    end
  end

  assign scan_out = chain[0];

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int exp_lat(input int n);
    return (n == 0) ? 1 : 1 + 4 * (n + 1 + EXTRA);
  endfunction

  int cap0, sh0;

  // Accept a transaction and wait (bounded) for oDone; optionally pulse iStart at cycle poke.
  task automatic run_txn(input int n, input int poke, output int lat);
    @(posedge clk); #1;
    cap0 = cap_edges;
    sh0 = shift_edges;
    start = 1'b1;
    len = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check_eq("busy_after_accept", 256'(busy), 256'(1));
    while (!done && lat < 5000) begin
      if (lat == poke) begin
        start = 1'b1;
        len = 9'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check_eq("done_seen", 256'(done), 256'(1));
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    check_eq("done_one_cycle", 256'(done), 256'(0));
    check_eq("idle_after_done", 256'(busy), 256'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 256'(busy), 256'(0));
    check_eq({tag, "_done"}, 256'(done), 256'(0));
    check_eq({tag, "_data"}, 256'(data), 256'(0));
    check_eq({tag, "_err"}, 256'(chain_err), 256'(0));
    check_eq({tag, "_sclk"}, 256'(scan_clk), 256'(0));
    check_eq({tag, "_ctrl"}, 256'(scan_ctrl), 256'(0));
    check_eq({tag, "_sin"}, 256'(scan_in), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic 37-bit capture.
    chain_len = 37;
    pdata = 256'h1_2345_6789;
    run_txn(37, 0, lat);
    check_eq("basic_lat", 256'(lat), 256'(exp_lat(37)));
    check_eq("basic_data", 256'(data), 256'h1_2345_6789);
    check_eq("basic_cap_edges", 256'(cap_edges - cap0), 256'(1));
    check_eq("basic_shift_edges", 256'(shift_edges - sh0), 256'(37 + EXTRA));
    check_eq("basic_err", 256'(chain_err), 256'(0));
    after_done();
    check_eq("data_held", 256'(data), 256'h1_2345_6789);

    // Zero length: immediate done, no scan activity, data cleared.
    run_txn(0, 0, lat);
    check_eq("zero_lat", 256'(lat), 256'(1));
    check_eq("zero_data", 256'(data), 256'(0));
    check_eq("zero_edges", 256'(cap_edges - cap0 + shift_edges - sh0), 256'(0));
    after_done();

    // Short chain, full length.
    chain_len = 8;
    pdata = 256'hA5;
    run_txn(8, 0, lat);
    check_eq("byte_lat", 256'(lat), 256'(exp_lat(8)));
    check_eq("byte_data", 256'(data), 256'hA5);
    after_done();

    // Len shorter than the chain: only the low Len bits appear.
    chain_len = 64;
    pdata = 256'hDEAD_BEEF_CAFE_F00D;
    run_txn(20, 0, lat);
    check_eq("partial_lat", 256'(lat), 256'(exp_lat(20)));
    check_eq("partial_data", 256'(data), 256'hE_F00D);
    after_done();

    // Start while busy is ignored.
    chain_len = 37;
    pdata = 256'h1_2345_6789;
    d0 = done_cnt;
    run_txn(37, 60, lat);
    check_eq("busy_lat", 256'(lat), 256'(exp_lat(37)));
    check_eq("busy_data", 256'(data), 256'h1_2345_6789);
    after_done();
    check_eq("busy_single_done", 256'(done_cnt), 256'(d0 + 1));

    // Reset around shift period 10.
    pdata = 256'h1_2345_6789;
    @(posedge clk); #1;
    start = 1'b1;
    len = 9'd37;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (10) @(posedge clk);
    #1;
    check_eq("midrst_no_done", 256'(done_cnt), 256'(d0));
    run_txn(37, 0, lat);
    check_eq("midrst_restart_lat", 256'(lat), 256'(exp_lat(37)));
    check_eq("midrst_restart_data", 256'(data), 256'h1_2345_6789);
    after_done();

    // Length clamp to MAXLEN.
    chain_len = 256;
    pdata = {4{64'h0123_4567_89AB_CDEF}};
    run_txn(MAXLEN + 5, 0, lat);
    check_eq("clamp_lat", 256'(lat), 256'(exp_lat(MAXLEN)));
    check_eq("clamp_data", 256'(data), {4{64'h0123_4567_89AB_CDEF}});
    check_eq("clamp_shift_edges", 256'(shift_edges - sh0), 256'(MAXLEN + EXTRA));
    after_done();

`ifdef WATCH_SCAN_CHAIN_CHECK_EN
    // Chain one bit shorter than Len: marker arrives a period early.
    chain_len = 36;
    pdata = 256'h2_3456_789A;
    run_txn(37, 0, lat);
    check_eq("short_chain_lat", 256'(lat), 256'(exp_lat(37)));
    check_eq("short_chain_err", 256'(chain_err), 256'(1));
    after_done();
    chain_len = 37;
    pdata = 256'h1_2345_6789;
    run_txn(37, 0, lat);
    check_eq("err_cleared", 256'(chain_err), 256'(0));
    after_done();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_scan_master.md
Name: watch_scan_master

Overview:
- Debugger-side master for the CPU watch scan chains.
- Generates the scan clock and the ShiftDR/CaptureDR controls, captures a chain's contents, then serially shifts them out and assembles them into a parallel word for the debugger host logic.
- Sits between the debugger core and the CPU's iScanClk/iScanIn/iScanCtrlN/oScanOutN pins; one instance drives one chain.

Parameters:
- MAXLEN, 256: maximum chain length in bits; width of oData.
- CLKDIV, 2: scan clock half-period in Clk cycles; must be ≥1.
- LW, $clog2(MAXLEN+1): width of iLen; derived, not overridden.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- iStart  in  1  request one capture+shift transaction; accepted only in IDLE.
- iLen  in  LW  chain length in bits for this transaction; sampled on accept.
- oBusy  out  1  high from the cycle after accept until DONE inclusive.
- oDone  out  1  one-cycle pulse when oData is valid.
- oData  out  MAXLEN  captured chain bits; bit k = chain bit k; bits ≥ Len are 0.
- oChainErr  out  1  chain-length check failed (see Optional Feature).
- oScanClk  out  1  scan clock to chain TCK.
- oScanIn  out  1  serial data into the chain.
- iScanOut  in  1  serial data from the chain; presents chain bit 0 first.
- oScanCtrl  out  2  {ShiftDR, CaptureDR} to the chain.

Behaviour:
- Chain model:
  - On an oScanClk rising edge with CaptureDR=1, the chain loads its parallel data.
  - With ShiftDR=1 it shifts one place toward ScanOut; ScanIn enters the MSB.
- States: IDLE, CAPTURE, SHIFT, DONE.
- Reset values: state IDLE; oScanClk 0; oScanCtrl 00; oScanIn 0; oBusy 0; oDone 0; oData 0; oChainErr 0.
- Reset mid-transaction returns to IDLE in one cycle, with no oDone pulse.
- Scan clock period:
  - Every period is 2*CLKDIV Clk cycles: oScanClk low for CLKDIV cycles, then high for CLKDIV cycles.
  - oScanCtrl and oScanIn change only on the Clk edge where oScanClk goes low, so they are stable around each rising edge.
- IDLE:
  - oScanClk 0, oScanCtrl 00.
  - iStart with iLen=0 → DONE directly; oData cleared.
  - iStart with iLen>MAXLEN → Len clamped to MAXLEN.
  - Otherwise latch Len and go to CAPTURE.
- CAPTURE: oScanCtrl=01 for exactly one scan period, then SHIFT.
- SHIFT:
  - oScanCtrl=10 for Len periods (Len+1 with the check feature).
  - In the last Clk cycle of each low half, sample iScanOut into oData[bitcnt], then increment bitcnt.
  - A rising edge follows every sample.
- DONE: oScanCtrl 00, oScanClk 0, oDone=1 for one cycle, then IDLE.
- Latency: accept in cycle T → oDone in cycle T+1+2*CLKDIV*(Len+1); Len=0 → oDone in T+1.
- Busy handling: iStart while oBusy is ignored and not queued.
- oData holds its value until the next accepted transaction, and is cleared on accept.

Optional Feature:
- Macro: WATCH_SCAN_CHAIN_CHECK_EN.
- Defined:
  - During the first shift period oScanIn=1 (marker); in later periods it is 0.
  - One extra shift period is added after the Len data periods; its pre-edge sample must be 1.
  - oChainErr is set in DONE if that sample ≠ 1, and cleared on accept.
  - Latency becomes T+1+2*CLKDIV*(Len+2).
- Not defined: oScanIn constant 0, no extra period, oChainErr tied 0.

Decomposition:
- Shared package debug_defs holds:
  - t_scan_state enum (IDLE, CAPTURE, SHIFT, DONE).
  - Constants SCAN_CTRL_IDLE=2'b00, SCAN_CTRL_CAPTURE=2'b01, SCAN_CTRL_SHIFT=2'b10.
- One sub-module, scan_clk_gen:
  - Half-period counter producing oScanClk, a fall tick and a pre-rise sample tick.
  - Has an enable input; stays low when disabled.

Test Plan:
- Basic capture: behavioural chain of 37 bits holding 37'h1_2345_6789, CLKDIV=2, iLen=37 → oData=37'h1_2345_6789 (upper bits 0); oDone 153 cycles after accept; exactly 38 oScanClk rising edges (1 with CaptureDR, 37 with ShiftDR).
- Zero length: iLen=0 → oDone at T+1; no oScanClk edges; oData=0.
- Start while busy: iStart pulsed mid-SHIFT → ignored; single oDone; data unchanged.
- Reset mid-shift: Reset at shift period 10 → next cycle IDLE with all outputs at reset values; no oDone; a following start completes normally.
- Length clamp: iLen=MAXLEN+5 with a 256-bit chain → 256 shift periods; oData equals the chain contents.
- Chain check (macro defined): chain length 37, iLen=37 → oChainErr=0, oDone at T+1+4*39. Chain length 36, iLen=37 → oChainErr=1.
